// File: rtl/mmu_pxr_ctl_if.sv
// Requester ports (CPU I/O page and console/debug) plus the MMU PXR programming port.
// Handshake: req is raised with we/be/addr/wdata stable and held until the one-cycle
// ack; rdata is valid while ack is high; req must drop the cycle after ack.
interface mmu_pxr_ctl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;

  logic        dbg_req;
  logic        dbg_we;
  logic [1:0]  dbg_be;
  logic [7:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic [15:0] dbg_rdata;

  logic        pxr_rd;
  logic        pxr_wr;
  logic [1:0]  pxr_be;
  logic [7:0]  pxr_addr;
  logic [15:0] pxr_data_in;
  logic [15:0] pxr_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_in,
    input  pxr_data_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_in,
    output pxr_data_out
  );
endinterface

// File: rtl/mmu_pxr_ctl.sv
// Owns the MMU PAR/PDR/MMR programming port: hardware clear of the 128 PDR/PAR
// entries after reset or on init_req, then round-robin CPU/console access.
module mmu_pxr_ctl #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] INIT_DATA      = 16'o000000
) (
  input  logic         clk,
  input  logic         local_reset,
  input  logic         init_req,
  output logic         busy,
  output logic [1:0]   fsm_state,
  mmu_pxr_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  state_t      state;
  logic [6:0]  idx;
  logic        last_grant;
  logic        gnt;
  logic        acc_we;
  logic        pend_init;

  logic        init_go;
  logic        pick_dbg;
  logic        sel_we;
  logic [1:0]  sel_be;
  logic [7:0]  sel_addr;
  logic [15:0] sel_wdata;

  // MMR1/MMR2 are read-only from the programming port; their writes are acked but dropped.
  function automatic logic is_mmr12(input logic [7:0] a);
    return (a[7:6] == 2'b10) && ((a[1:0] == 2'b01) || (a[1:0] == 2'b10));
  endfunction

  assign init_go   = CLEAR_ON_RESET && init_req;
  assign pick_dbg  = bus.dbg_req && (!bus.cpu_req || (last_grant == GNT_CPU));
  assign sel_we    = pick_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_be    = pick_dbg ? bus.dbg_be    : bus.cpu_be;
  assign sel_addr  = pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
  assign fsm_state = state;

  // Port outputs are registered: the value loaded at an edge is what the MMU sees
  // during the following cycle, so the INIT write of idx appears one cycle later.
  always_ff @(posedge clk or posedge local_reset) begin
    if (local_reset) begin
      state           <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
      idx             <= '0;
      last_grant      <= GNT_CPU;
      gnt             <= GNT_CPU;
      acc_we          <= 1'b0;
      pend_init       <= 1'b0;
      busy            <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.dbg_ack     <= 1'b0;
      bus.dbg_rdata   <= '0;
      bus.pxr_rd      <= 1'b0;
      bus.pxr_wr      <= 1'b0;
      bus.pxr_be      <= '0;
      bus.pxr_addr    <= '0;
      bus.pxr_data_in <= '0;
    end else begin
      busy            <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.dbg_ack     <= 1'b0;
      bus.pxr_rd      <= 1'b0;
      bus.pxr_wr      <= 1'b0;
      bus.pxr_be      <= '0;
      bus.pxr_addr    <= '0;
      bus.pxr_data_in <= '0;
      case (state)
        S_INIT: begin
          busy            <= 1'b1;
          bus.pxr_wr      <= 1'b1;
          bus.pxr_be      <= 2'b11;
          bus.pxr_data_in <= INIT_DATA;
          bus.pxr_addr    <= {1'b0, idx[6], idx[5:0]};
          if (init_go) begin
            idx <= '0;
          end else if (idx == 7'd127) begin
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            idx <= idx + 7'd1;
          end
        end
        S_IDLE: begin
          if (pend_init || init_go) begin
            pend_init <= 1'b0;
            idx       <= '0;
            state     <= S_INIT;
          end else if (bus.cpu_req || bus.dbg_req) begin
            gnt             <= pick_dbg;
            last_grant      <= pick_dbg;
            acc_we          <= sel_we;
            bus.pxr_addr    <= sel_addr;
            bus.pxr_be      <= sel_be;
            bus.pxr_data_in <= sel_wdata;
            bus.pxr_rd      <= !sel_we;
            bus.pxr_wr      <= sel_we && !is_mmr12(sel_addr);
            state           <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (init_go) pend_init <= 1'b1;
          if (!acc_we) begin
            if (gnt == GNT_DBG) bus.dbg_rdata <= bus.pxr_data_out;
            else                bus.cpu_rdata <= bus.pxr_data_out;
          end
          bus.cpu_ack <= (gnt == GNT_CPU);
          bus.dbg_ack <= (gnt == GNT_DBG);
          state       <= S_ACK;
        end
        S_ACK: begin
          if (init_go) pend_init <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_pxr_ctl.sv
// Bench for mmu_pxr_ctl: a behavioural MMU register file behind the PXR port,
// directed vectors, corner-case sequences and randomized request pairs.
module tb_mmu_pxr_ctl;

  logic       clk = 1'b0;
  logic       local_reset;
  logic       init_req;
  logic       busy;
  logic [1:0] fsm_state;

  mmu_pxr_ctl_if bus ();

  mmu_pxr_ctl #(
    .CLEAR_ON_RESET (1'b1),
    .INIT_DATA      (16'o000000)
  ) dut (
    .clk         (clk),
    .local_reset (local_reset),
    .init_req    (init_req),
    .busy        (busy),
    .fsm_state   (fsm_state),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- MMU register file (no reset; powers up as junk) ----------------
  logic [15:0] mmu_mem [256];
  logic [15:0] env_t;
  int          wr_cnt  = 0;
  bit          overlap = 1'b0;

  assign bus.pxr_data_out = mmu_mem[bus.pxr_addr];

  initial begin
    for (int i = 0; i < 256; i++) mmu_mem[i] = 16'hDEAD;
    forever begin
      @(posedge clk);
      if (bus.pxr_rd && bus.pxr_wr) overlap = 1'b1;
      if (bus.pxr_wr) begin
        wr_cnt++;
        env_t = mmu_mem[bus.pxr_addr];
        if (bus.pxr_be[0]) env_t[7:0]  = bus.pxr_data_in[7:0];
        if (bus.pxr_be[1]) env_t[15:8] = bus.pxr_data_in[15:8];
        if (bus.pxr_addr[7:6] == 2'b01) env_t = env_t & 16'o007777;
        mmu_mem[bus.pxr_addr] = env_t;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  logic [15:0] ref_mem [256];
  bit          ref_last_dbg = 1'b0;

  task automatic model_txn(input txn_t t, output logic [15:0] rd, output int wrs);
    logic [15:0] v;
    rd  = 16'h0;
    wrs = 0;
    if (!t.we) begin
      rd = ref_mem[t.addr];
    end else if (!(t.addr[7:6] == 2'b10 && (t.addr[1:0] == 2'b01 || t.addr[1:0] == 2'b10))) begin
      v = ref_mem[t.addr];
      if (t.be[0]) v[7:0]  = t.wdata[7:0];
      if (t.be[1]) v[15:8] = t.wdata[15:8];
      if (t.addr[7:6] == 2'b01) v = v & 16'o007777;
      ref_mem[t.addr] = v;
      wrs = 1;
    end
  endtask

  // One arbitration round: either or both requesters raise req while the DUT is idle.
  task automatic run_pair(input bit cv, input txn_t ct, input bit dv, input txn_t dt,
                          output logic [15:0] cpu_got, output logic [15:0] dbg_got,
                          output logic [15:0] cpu_exp, output logic [15:0] dbg_exp,
                          output int wrs_got);
    bit dbg_first, cdone, ddone, dual;
    int w1, w2, wr0, cpu_lat, dbg_lat, cpu_n, dbg_n;
    dbg_first = dv && (!cv || !ref_last_dbg);
    cpu_exp = '0; dbg_exp = '0; w1 = 0; w2 = 0;
    if (dbg_first) begin
      model_txn(dt, dbg_exp, w1);
      if (cv) model_txn(ct, cpu_exp, w2);
    end else begin
      model_txn(ct, cpu_exp, w1);
      if (dv) model_txn(dt, dbg_exp, w2);
    end
    ref_last_dbg = (cv && dv) ? !dbg_first : dv;

    wr0 = wr_cnt; cpu_got = '0; dbg_got = '0;
    cpu_lat = 0; dbg_lat = 0; cpu_n = 0; dbg_n = 0; dual = 1'b0;
    cdone = !cv; ddone = !dv;
    bus.cpu_req = cv; bus.cpu_we = ct.we; bus.cpu_be = ct.be;
    bus.cpu_addr = ct.addr; bus.cpu_wdata = ct.wdata;
    bus.dbg_req = dv; bus.dbg_we = dt.we; bus.dbg_be = dt.be;
    bus.dbg_addr = dt.addr; bus.dbg_wdata = dt.wdata;
    for (int cyc = 1; cyc <= 12 && !(cdone && ddone); cyc++) begin
      @(negedge clk);
      if (bus.cpu_ack && bus.dbg_ack) dual = 1'b1;
      if (bus.cpu_ack) begin
        cpu_n++; cpu_lat = cyc; cpu_got = bus.cpu_rdata; cdone = 1'b1; bus.cpu_req = 1'b0;
      end
      if (bus.dbg_ack) begin
        dbg_n++; dbg_lat = cyc; dbg_got = bus.dbg_rdata; ddone = 1'b1; bus.dbg_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", 32'({bus.cpu_ack, bus.dbg_ack}), 32'd0);
    chk("dual_ack", 32'(dual), 32'd0);
    chk("cpu_ack_count", 32'(cpu_n), 32'(cv));
    chk("dbg_ack_count", 32'(dbg_n), 32'(dv));
    if (cv) chk("cpu_latency", 32'(cpu_lat), (dv && dbg_first) ? 32'd5 : 32'd2);
    if (dv) chk("dbg_latency", 32'(dbg_lat), (cv && !dbg_first) ? 32'd5 : 32'd2);
    wrs_got = wr_cnt - wr0;
    chk("pxr_wr_pulses", 32'(wrs_got), 32'(w1 + w2));
  endtask

  // Watches one full clear; optionally raises a CPU read of PAR 101 mid-clear.
  task automatic check_init_run(input string name, input int raise_at);
    int n, bad;
    bit ended, early_ack;
    n = 0; bad = 0; ended = 1'b0; early_ack = 1'b0;
    for (int cyc = 0; cyc < 300 && !ended; cyc++) begin
      @(negedge clk);
      if (bus.cpu_ack) early_ack = 1'b1;
      if (bus.pxr_wr) begin
        if (bus.pxr_addr != n[7:0] || bus.pxr_data_in != 16'h0 || bus.pxr_be != 2'b11 || !busy)
          bad++;
        n++;
        if (n == raise_at) begin
          bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_be = 2'b11;
          bus.cpu_addr = 8'o101; bus.cpu_wdata = 16'h0;
        end
      end else if (n > 0) begin
        ended = 1'b1;
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
      end
    end
    chk({name, "_writes"}, 32'(n), 32'd128);
    chk({name, "_bad_writes"}, 32'(bad), 32'd0);
    chk({name, "_no_early_ack"}, 32'(early_ack), 32'd0);
    for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0;
  endtask

  function automatic txn_t mk_txn(input logic we, input logic [1:0] be,
                                  input logic [7:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.be    = 2'($urandom_range(0, 3));
    t.addr  = ($urandom_range(0, 7) == 0) ? (8'o200 + 8'($urandom_range(0, 3)))
                                          : 8'($urandom_range(0, 127));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  typedef struct {
    bit          is_dbg;
    txn_t        t;
    logic [15:0] exp_rd;
    int          exp_wrs;
  } vec_t;

  function automatic vec_t mk_vec(input bit is_dbg, input logic we, input logic [1:0] be,
                                  input logic [7:0] addr, input logic [15:0] wdata,
                                  input logic [15:0] exp_rd, input int exp_wrs);
    vec_t v;
    v.is_dbg = is_dbg; v.t = mk_txn(we, be, addr, wdata);
    v.exp_rd = exp_rd; v.exp_wrs = exp_wrs;
    return v;
  endfunction

  vec_t        vecs [13];
  txn_t        idle_t;
  logic [15:0] cg, dg, ce, de;
  int          wg;
  bit          ack_seen;
  int          ack_wait;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'hDEAD;
    idle_t = mk_txn(1'b0, 2'b00, 8'h00, 16'h0);
    local_reset = 1'b1; init_req = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = '0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_be = '0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

    //                 dbg   we    be     addr    wdata       exp_rd      wrs
    vecs[0]  = mk_vec(1'b0, 1'b0, 2'b11, 8'o100, 16'h0,      16'h0,      0);
    vecs[1]  = mk_vec(1'b0, 1'b1, 2'b11, 8'o101, 16'o1234,   16'h0,      1);
    vecs[2]  = mk_vec(1'b0, 1'b0, 2'b11, 8'o101, 16'h0,      16'o1234,   0);
    vecs[3]  = mk_vec(1'b1, 1'b1, 2'b11, 8'o102, 16'o171234, 16'h0,      1);
    vecs[4]  = mk_vec(1'b1, 1'b0, 2'b11, 8'o102, 16'h0,      16'o001234, 0);
    vecs[5]  = mk_vec(1'b1, 1'b1, 2'b01, 8'o005, 16'hABCD,   16'h0,      1);
    vecs[6]  = mk_vec(1'b0, 1'b0, 2'b11, 8'o005, 16'h0,      16'h00CD,   0);
    vecs[7]  = mk_vec(1'b0, 1'b1, 2'b10, 8'o005, 16'h1234,   16'h0,      1);
    vecs[8]  = mk_vec(1'b1, 1'b0, 2'b11, 8'o005, 16'h0,      16'h12CD,   0);
    vecs[9]  = mk_vec(1'b0, 1'b1, 2'b11, 8'o201, 16'o7777,   16'h0,      0);
    vecs[10] = mk_vec(1'b0, 1'b0, 2'b11, 8'o201, 16'h0,      16'hDEAD,   0);
    vecs[11] = mk_vec(1'b0, 1'b1, 2'b11, 8'o203, 16'o4,      16'h0,      1);
    vecs[12] = mk_vec(1'b0, 1'b0, 2'b11, 8'o203, 16'h0,      16'o4,      0);

    // Reset values, then the power-on clear.
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({bus.pxr_rd, bus.pxr_wr}), 32'd0);
    chk("rst_addr", 32'(bus.pxr_addr), 32'd0);
    chk("rst_acks", 32'({bus.cpu_ack, bus.dbg_ack}), 32'd0);
    chk("rst_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 32'd0);
    local_reset = 1'b0;
    check_init_run("por_init", -1);

    // Directed single-requester vectors.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_dbg) run_pair(1'b0, idle_t, 1'b1, vecs[i].t, cg, dg, ce, de, wg);
      else                run_pair(1'b1, vecs[i].t, 1'b0, idle_t, cg, dg, ce, de, wg);
      if (!vecs[i].t.we)
        chk($sformatf("vec%0d_rdata", i), 32'(vecs[i].is_dbg ? dg : cg), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_wrs", i), 32'(wg), 32'(vecs[i].exp_wrs));
    end

    // Both requesters held together for four reads: dbg, cpu, dbg, cpu.
    run_pair(1'b1, mk_txn(1'b0, 2'b11, 8'o005, 16'h0), 1'b1, mk_txn(1'b0, 2'b11, 8'o101, 16'h0),
             cg, dg, ce, de, wg);
    chk("tie1_cpu_rdata", 32'(cg), 32'h12CD);
    chk("tie1_dbg_rdata", 32'(dg), 32'(16'o1234));
    run_pair(1'b1, mk_txn(1'b0, 2'b11, 8'o203, 16'h0), 1'b1, mk_txn(1'b0, 2'b11, 8'o100, 16'h0),
             cg, dg, ce, de, wg);
    chk("tie2_cpu_rdata", 32'(cg), 32'(16'o4));
    chk("tie2_dbg_rdata", 32'(dg), 32'h0);

    // init_req during a dbg read's ACCESS cycle.
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_be = 2'b11; bus.dbg_addr = 8'o101;
    @(negedge clk);
    chk("irq_access_rd", 32'(bus.pxr_rd), 32'd1);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    chk("irq_dbg_ack", 32'(bus.dbg_ack), 32'd1);
    chk("irq_dbg_rdata", 32'(bus.dbg_rdata), 32'(ref_mem[8'o101]));
    bus.dbg_req = 1'b0;
    ref_last_dbg = 1'b1;
    check_init_run("irq_init", 10);
    ack_wait = 0;
    for (int cyc = 1; cyc <= 10 && ack_wait == 0; cyc++) begin
      @(negedge clk);
      if (bus.cpu_ack) begin
        ack_wait = cyc;
        chk("irq_cpu_busy_low", 32'(busy), 32'd0);
        chk("irq_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    chk("irq_cpu_ack_wait", 32'(ack_wait), 32'd1);
    ref_last_dbg = 1'b0;
    @(negedge clk);

    // Asynchronous reset during a write ACCESS.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_be = 2'b11;
    bus.cpu_addr = 8'o050; bus.cpu_wdata = 16'h5555;
    @(negedge clk);
    chk("rst_access_wr", 32'(bus.pxr_wr), 32'd1);
    local_reset = 1'b1;
    #1;
    chk("rst_async_strobes", 32'({bus.pxr_rd, bus.pxr_wr}), 32'd0);
    chk("rst_async_addr", 32'(bus.pxr_addr), 32'd0);
    bus.cpu_req = 1'b0;
    ack_seen = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (bus.cpu_ack) ack_seen = 1'b1;
    end
    chk("rst_no_ack", 32'(ack_seen), 32'd0);
    local_reset = 1'b0;
    ref_last_dbg = 1'b0;
    check_init_run("rst_init", -1);

    // Randomized request pairs against the model.
    for (int k = 0; k < 30; k++) begin
      bit   cv, dv;
      txn_t ct, dt;
      cv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!cv && !dv) cv = 1'b1;
      ct = rand_txn();
      dt = rand_txn();
      run_pair(cv, ct, dv, dt, cg, dg, ce, de, wg);
      if (cv && !ct.we) chk("rnd_cpu_rdata", 32'(cg), 32'(ce));
      if (dv && !dt.we) chk("rnd_dbg_rdata", 32'(dg), 32'(de));
    end

    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_pxr_ctl.md
Name: mmu_pxr_ctl

Overview:
Controller that owns the MMU's PAR/PDR/MMR programming port (pxr_rd/pxr_wr/pxr_be/pxr_addr/pxr_data_in/pxr_data_out). After reset, and on request, it clears all 128 PDR/PAR entries in hardware, because the MMU register file has no reset. It then arbitrates the port round-robin between the CPU I/O-page path and the console/debug path. It sits between bus.v/iopage decode and the mmu instance.

Parameters:
CLEAR_ON_RESET, 1, 1 = enter INIT after reset; 0 = enter IDLE after reset and ignore init_req.
INIT_DATA, 16'o000000, value written to every PDR/PAR entry during INIT.

Ports:
clk  in  1  clock
local_reset  in  1  asynchronous, active-high reset
init_req  in  1  single-cycle pulse (soft reset); requests a re-clear of the PXR file
busy  out  1  high while INIT is in progress
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_be  in  2  byte enables
cpu_addr  in  8  pxr address, same encoding as mmu pxr_addr
cpu_wdata  in  16  write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  16  read data, valid while cpu_ack is high
dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same directions, widths and meanings as the cpu_* ports, for the console/debug path
pxr_rd  out  1  MMU read strobe
pxr_wr  out  1  MMU write strobe
pxr_be  out  2  to MMU
pxr_addr  out  8  to MMU
pxr_data_in  out  16  write data to MMU
pxr_data_out  in  16  read data from MMU (combinational)

Behaviour:
- Reset (asynchronous): all outputs 0. idx=0, last_grant=CPU, pend_init=0. state=INIT if CLEAR_ON_RESET, otherwise IDLE. Any access in flight is dropped without an ack.
- States: INIT, IDLE, ACCESS, ACK.
- INIT:
  - Each cycle: pxr_wr=1, pxr_be=2'b11, pxr_data_in=INIT_DATA, pxr_addr={1'b0, idx[6], idx[5:0]}. idx 0..63 covers the PDRs (addr 000-077 octal); idx 64..127 covers the PARs (addr 100-177 octal).
  - idx increments each cycle. After the idx=127 write, go to IDLE and clear idx. INIT lasts exactly 128 cycles.
  - busy=1 throughout INIT. Requests are not granted and not acked; they stay pending.
  - init_req during INIT restarts idx at 0.
- IDLE:
  - If pend_init or init_req is set: go to INIT, clear pend_init.
  - Else if either req is high: grant it. If both are high, grant the requester opposite to last_grant (first tie after reset goes to dbg). Latch the granted we/be/addr/wdata and the grant id, update last_grant, go to ACCESS.
- ACCESS (1 cycle):
  - Drive pxr_addr/pxr_be/pxr_data_in from the latched values.
  - Read: pxr_rd=1; capture pxr_data_out into the granted requester's rdata register at the clock edge.
  - Write: pxr_wr=1, except for writes to MMR1/MMR2 (addr matching 10xxxx01 or 10xxxx10), which are suppressed (pxr_wr stays 0) but still acked.
  - Go to ACK.
- ACK (1 cycle): granted ack=1 and rdata valid; the other requester's ack stays 0. Go to IDLE. The rdata registers hold their value until the next read by the same requester.
- Latency: request seen in IDLE to ack = 2 cycles; back-to-back throughput is one access per 3 cycles.
- Requester rule: the requester must drop req in the cycle after ack. A req still high in IDLE after ACK counts as a new transaction.
- init_req while in ACCESS or ACK: set pend_init. The current access completes and acks, then INIT starts from IDLE. init_req in the IDLE decision cycle takes priority over a pending request.
- pxr_rd and pxr_wr are never both 1. Outside ACCESS/INIT both strobes are 0 and pxr_addr/pxr_be/pxr_data_in are 0.

Test Plan:
- Reset deassert with CLEAR_ON_RESET=1: exactly 128 consecutive pxr_wr cycles, addr 000..177 octal in order, data 0, be=11; busy falls the cycle after addr 177. A read of PAR 100 afterwards returns 0.
- CPU write addr 101, be=11, data 16'o1234, then CPU read addr 101: each ack arrives 2 cycles after req; cpu_rdata=16'o1234 (12-bit PAR mask applied by the MMU); dbg_ack stays 0.
- cpu_req and dbg_req held high together for 4 transactions: grants go dbg, cpu, dbg, cpu; each ack lasts one cycle; rdata lands on the correct port.
- CPU write addr 201 (MMR1) data 16'o7777: cpu_ack pulses and pxr_wr never asserts. Write addr 203 (MMR3) data 16'o4: pxr_wr asserts.
- init_req pulse during a dbg read's ACCESS cycle: dbg_ack completes with correct data, then a full 128-cycle INIT follows. A cpu_req raised during INIT is acked only after busy falls.
- local_reset asserted during ACCESS: strobes drop to 0 asynchronously, no ack is issued, and INIT restarts from idx 0 after deassert.
